// File: rtl/dma_pkg.sv
`default_nettype none
// dma_pkg: transfer-size encoding and the byte-count helper shared by the DMA data path.
package dma_pkg;

   typedef enum logic [2:0] {
      SZ_BYTE  = 3'd0,
      SZ_HALF  = 3'd1,
      SZ_WORD  = 3'd2,
      SZ_DWORD = 3'd3
   } dma_size_e;

   // Codes wider than the bus saturate at one full beat.
   function automatic logic [3:0] size_bytes(input logic [2:0] size, input int unsigned bus_bytes);
      int unsigned n;
      n = 32'd1 << size;
      if (n > bus_bytes) n = bus_bytes;
      return 4'(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dma_pack_fifo_if.sv
`default_nettype none
// dma_pack_fifo_if: push/pop/commit handshake bundle between the AHB engines and the pack FIFO.
interface dma_pack_fifo_if #(
   parameter int BUS_BYTES   = 4,
   parameter int DEPTH_BYTES = 256
);
   localparam int DW = 8 * BUS_BYTES;
   localparam int LW = $clog2(DEPTH_BYTES) + 1;

   logic          flush;
   logic          wr_en;
   logic [2:0]    wr_size;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          rd_en;
   logic [2:0]    rd_size;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_commit;
   logic          rd_rewind;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          underflow;

   modport master (
      output flush, wr_en, wr_size, wr_data, rd_en, rd_size, rd_commit, rd_rewind,
      input  wr_ready, rd_data, rd_valid, level, full, empty, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, wr_size, wr_data, rd_en, rd_size, rd_commit, rd_rewind,
      output wr_ready, rd_data, rd_valid, level, full, empty, overflow, underflow
   );

endinterface
`default_nettype wire

// File: rtl/dma_byte_ram.sv
`default_nettype none
// dma_byte_ram: BUS_BYTES byte-lane banks; byte address a lives in lane a%BUS_BYTES, row a/BUS_BYTES.
module dma_byte_ram #(
   parameter int BUS_BYTES   = 4,
   parameter int DEPTH_BYTES = 256
) (
   input  wire logic                           clk,
   input  wire logic                           i_wr_en,
   input  wire logic [$clog2(DEPTH_BYTES)-1:0] i_wr_addr,
   input  wire logic [$clog2(DEPTH_BYTES):0]   i_wr_cnt,
   input  wire logic [8*BUS_BYTES-1:0]         i_wr_data,
   input  wire logic [$clog2(DEPTH_BYTES)-1:0] i_rd_addr,
   input  wire logic [$clog2(DEPTH_BYTES):0]   i_rd_cnt,
   output logic      [8*BUS_BYTES-1:0]         o_rd_data
);
   localparam int AW   = $clog2(DEPTH_BYTES);
   localparam int LB   = $clog2(BUS_BYTES);
   localparam int RW   = AW - LB;
   localparam int ROWS = DEPTH_BYTES / BUS_BYTES;
   localparam int DW   = 8 * BUS_BYTES;

   logic [7:0]    w_lane_q [BUS_BYTES];
   logic [AW-1:0] w_rk     [BUS_BYTES];

   for (genvar L = 0; L < BUS_BYTES; L++) begin : g_lane
      logic [7:0]    r_mem [ROWS];
      logic [AW-1:0] w_wk;
      logic [RW-1:0] w_wrow;
      logic [RW-1:0] w_rrow;
      logic          w_wen;

      // w_wk is the payload byte index that lands on this lane for the current base address.
      assign w_wk     = (AW'(L) - i_wr_addr) & AW'(BUS_BYTES - 1);
      assign w_wrow   = RW'((i_wr_addr + w_wk) >> LB);
      assign w_wen    = i_wr_en && ({1'b0, w_wk} < i_wr_cnt);

      assign w_rk[L]  = (AW'(L) - i_rd_addr) & AW'(BUS_BYTES - 1);
      assign w_rrow   = RW'((i_rd_addr + w_rk[L]) >> LB);

      always_ff @(posedge clk) begin
         if (w_wen) r_mem[w_wrow] <= 8'(i_wr_data >> {w_wk, 3'b000});
      end

      assign w_lane_q[L] = r_mem[w_rrow];
   end

   always_comb begin
      o_rd_data = '0;
      for (int l = 0; l < BUS_BYTES; l++) begin
         if ({1'b0, w_rk[l]} < i_rd_cnt)
            o_rd_data = o_rd_data | (DW'(w_lane_q[l]) << {w_rk[l], 3'b000});
      end
   end

endmodule
`default_nettype wire

// File: rtl/dma_pack_fifo.sv
`default_nettype none
// dma_pack_fifo: byte-granular pack/unpack FIFO with read-side commit/rewind for error replay.
module dma_pack_fifo
   import dma_pkg::*;
#(
   parameter int BUS_BYTES    = 4,
   parameter int DEPTH_BYTES  = 256,
   parameter int FALL_THROUGH = 1
) (
   input  wire logic       clk,
   input  wire logic       reset,
   dma_pack_fifo_if.slave  bus
);
   localparam int PW = $clog2(DEPTH_BYTES) + 1;
   localparam int AW = PW - 1;
   localparam int DW = 8 * BUS_BYTES;

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_ck_ptr;
   logic          r_overflow;
   logic          r_underflow;

   logic [PW-1:0] w_wr_n;
   logic [PW-1:0] w_rd_n;
   logic [PW-1:0] w_level;
   logic [PW-1:0] w_free;
   logic [PW-1:0] w_rd_next;
   logic          w_wr_ready;
   logic          w_rd_valid;
   logic          w_push;
   logic          w_pop;
   logic [DW-1:0] w_ram_data;

   assign w_wr_n     = PW'(size_bytes(bus.wr_size, BUS_BYTES));
   assign w_rd_n     = PW'(size_bytes(bus.rd_size, BUS_BYTES));
   assign w_level    = r_wr_ptr - r_rd_ptr;
   // Space is only returned on commit, so replayable bytes keep occupying the array.
   assign w_free     = PW'(DEPTH_BYTES) - (r_wr_ptr - r_ck_ptr);
   assign w_wr_ready = (w_free >= w_wr_n);
   assign w_rd_valid = (w_level >= w_rd_n);
   assign w_push     = bus.wr_en && w_wr_ready && !bus.flush;
   assign w_pop      = bus.rd_en && w_rd_valid && !bus.rd_rewind && !bus.flush;
   assign w_rd_next  = r_rd_ptr + w_rd_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_ck_ptr    <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= bus.wr_en && !w_wr_ready;
         r_underflow <= bus.rd_en && !w_rd_valid;
         if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ck_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + w_wr_n;
            if (bus.rd_rewind) begin
               r_rd_ptr <= r_ck_ptr;
            end else begin
               if (w_pop)         r_rd_ptr <= w_rd_next;
               if (bus.rd_commit) r_ck_ptr <= w_pop ? w_rd_next : r_rd_ptr;
            end
         end
      end
   end

   dma_byte_ram #(
      .BUS_BYTES   (BUS_BYTES),
      .DEPTH_BYTES (DEPTH_BYTES)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr[AW-1:0]),
      .i_wr_cnt  (w_wr_n),
      .i_wr_data (bus.wr_data),
      .i_rd_addr (r_rd_ptr[AW-1:0]),
      .i_rd_cnt  (w_rd_n),
      .o_rd_data (w_ram_data)
   );

   if (FALL_THROUGH != 0) begin : g_fall_through
      assign bus.rd_data = w_rd_valid ? w_ram_data : '0;
   end else begin : g_registered
      logic [DW-1:0] r_rd_data;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)         r_rd_data <= '0;
         else if (bus.flush) r_rd_data <= '0;
         else if (w_pop)     r_rd_data <= w_ram_data;
      end
      assign bus.rd_data = r_rd_data;
   end

   assign bus.wr_ready  = w_wr_ready;
   assign bus.rd_valid  = w_rd_valid;
   assign bus.level     = w_level;
   assign bus.full      = (w_free == '0);
   assign bus.empty     = (w_level == '0);
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_dma_pack_fifo.sv
`default_nettype none
// tb_dma_pack_fifo: byte-queue scoreboard driving a fall-through and a registered instance in lockstep.
module tb_dma_pack_fifo;
   import dma_pkg::*;

   localparam int BB = 4;
   localparam int DB = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [7:0]  sb_q [$];
   int          rd_off  = 0;
   logic [31:0] exp_reg = '0;
   logic [31:0] last_ft = '0;

   always #5 clk = ~clk;

   dma_pack_fifo_if #(.BUS_BYTES(BB), .DEPTH_BYTES(DB)) bus_ft ();
   dma_pack_fifo_if #(.BUS_BYTES(BB), .DEPTH_BYTES(DB)) bus_rg ();

   assign bus_rg.flush     = bus_ft.flush;
   assign bus_rg.wr_en     = bus_ft.wr_en;
   assign bus_rg.wr_size   = bus_ft.wr_size;
   assign bus_rg.wr_data   = bus_ft.wr_data;
   assign bus_rg.rd_en     = bus_ft.rd_en;
   assign bus_rg.rd_size   = bus_ft.rd_size;
   assign bus_rg.rd_commit = bus_ft.rd_commit;
   assign bus_rg.rd_rewind = bus_ft.rd_rewind;

   dma_pack_fifo #(.BUS_BYTES(BB), .DEPTH_BYTES(DB), .FALL_THROUGH(1)) u_ft (
      .clk(clk), .reset(reset), .bus(bus_ft)
   );
   dma_pack_fifo #(.BUS_BYTES(BB), .DEPTH_BYTES(DB), .FALL_THROUGH(0)) u_rg (
      .clk(clk), .reset(reset), .bus(bus_rg)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int nb(input logic [2:0] s);
      return (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
   endfunction

   task automatic drive_idle();
      bus_ft.flush = 0; bus_ft.wr_en = 0; bus_ft.wr_size = 0; bus_ft.wr_data = 0;
      bus_ft.rd_en = 0; bus_ft.rd_size = 0; bus_ft.rd_commit = 0; bus_ft.rd_rewind = 0;
   endtask

   task automatic op(input bit we, input logic [2:0] ws, input logic [31:0] wd,
                     input bit re, input logic [2:0] rs, input bit cm, input bit rw, input bit fl);
      int          wn, rn, used;
      bit          e_rdy, e_vld, acc_r;
      logic [31:0] e_data;
      wn = nb(ws);
      rn = nb(rs);
      bus_ft.wr_en = we; bus_ft.wr_size = ws; bus_ft.wr_data = wd;
      bus_ft.rd_en = re; bus_ft.rd_size = rs; bus_ft.rd_commit = cm;
      bus_ft.rd_rewind = rw; bus_ft.flush = fl;
      @(negedge clk);
      e_rdy = ((DB - sb_q.size()) >= wn);
      e_vld = ((sb_q.size() - rd_off) >= rn);
      check_val("wr_ready", 32'(bus_ft.wr_ready), 32'(e_rdy));
      check_val("rd_valid", 32'(bus_ft.rd_valid), 32'(e_vld));
      e_data = '0;
      if (e_vld) for (int k = 0; k < rn; k++) e_data[8*k +: 8] = sb_q[rd_off + k];
      last_ft = bus_ft.rd_data;
      if (re) check_val("rd_data_ft", bus_ft.rd_data, e_data);
      @(posedge clk);
      #1;
      drive_idle();
      acc_r = re && e_vld && !rw;
      if (fl) begin
         sb_q.delete();
         rd_off  = 0;
         exp_reg = '0;
      end else begin
         if (rw) begin
            rd_off = 0;
         end else begin
            if (acc_r) begin
               rd_off  = rd_off + rn;
               exp_reg = e_data;
            end
            if (cm) begin
               for (int k = 0; k < rd_off; k++) void'(sb_q.pop_front());
               rd_off = 0;
            end
         end
         if (we && e_rdy) for (int k = 0; k < wn; k++) sb_q.push_back(wd[8*k +: 8]);
      end
      used = sb_q.size();
      check_val("rd_data_reg", bus_rg.rd_data, exp_reg);
      check_val("overflow",    32'(bus_ft.overflow),  32'(we && !e_rdy));
      check_val("underflow",   32'(bus_ft.underflow), 32'(re && !e_vld));
      check_val("level",       32'(bus_ft.level), 32'(used - rd_off));
      check_val("empty",       32'(bus_ft.empty), 32'((used - rd_off) == 0));
      check_val("full",        32'(bus_ft.full),  32'(used == DB));
   endtask

   task automatic push(input logic [2:0] ws, input logic [31:0] wd);
      op(1, ws, wd, 0, 3'd0, 0, 0, 0);
   endtask

   task automatic pop(input logic [2:0] rs, input bit cm);
      op(0, 3'd0, 32'd0, 1, rs, cm, 0, 0);
   endtask

   task automatic idle();
      op(0, 3'd0, 32'd0, 0, 3'd0, 0, 0, 0);
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_level"},    32'(bus_ft.level), 32'd0);
      check_val({tag, "_empty"},    32'(bus_ft.empty), 32'd1);
      check_val({tag, "_full"},     32'(bus_ft.full),  32'd0);
      check_val({tag, "_wr_ready"}, 32'(bus_ft.wr_ready), 32'd1);
      check_val({tag, "_rd_valid"}, 32'(bus_ft.rd_valid), 32'd0);
      check_val({tag, "_rd_ft"},    bus_ft.rd_data, 32'd0);
      check_val({tag, "_rd_reg"},   bus_rg.rd_data, 32'd0);
      check_val({tag, "_ovf"},      32'(bus_ft.overflow),  32'd0);
      check_val({tag, "_udf"},      32'(bus_ft.underflow), 32'd0);
   endtask

   initial begin
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      reset = 1'b1;

      // Byte packing into a word.
      push(SZ_BYTE, 32'h11); push(SZ_BYTE, 32'h22); push(SZ_BYTE, 32'h33); push(SZ_BYTE, 32'h44);
      pop(SZ_WORD, 1);
      check_val("pack_word", last_ft, 32'h44332211);

      // Word unpacked into halves.
      push(SZ_WORD, 32'hAABBCCDD);
      pop(SZ_HALF, 1);
      check_val("half_lo", last_ft, 32'h0000CCDD);
      pop(SZ_HALF, 1);
      check_val("half_hi", last_ft, 32'h0000AABB);

      // Unaligned positions.
      push(SZ_BYTE, 32'h5A);
      push(SZ_WORD, 32'h04030201);
      pop(SZ_WORD, 1);
      check_val("unaligned_word", last_ft, 32'h0302015A);
      pop(SZ_BYTE, 1);
      check_val("unaligned_byte", last_ft, 32'h00000004);

      // Fill to the brim (crosses the array end), overflow, commit-gated credit.
      for (int i = 0; i < 4; i++) push(SZ_WORD, 32'h10203040 + 32'(i));
      push(SZ_BYTE, 32'h99);
      idle();
      pop(SZ_WORD, 0);
      idle();
      op(0, 3'd0, 32'd0, 0, 3'd0, 1, 0, 0);
      push(SZ_WORD, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) pop(SZ_WORD, 1);
      check_val("wrap_word", last_ft, 32'hDEADBEEF);

      // Rewind and replay from a flushed start.
      op(0, 3'd0, 32'd0, 0, 3'd0, 0, 0, 1);
      for (int i = 1; i <= 8; i++) push(SZ_BYTE, 32'(i));
      pop(SZ_WORD, 0);
      pop(SZ_WORD, 0);
      op(0, 3'd0, 32'd0, 0, 3'd0, 0, 1, 0);
      op(0, 3'd0, 32'd0, 1, SZ_WORD, 0, 1, 0);
      pop(SZ_WORD, 1);
      check_val("replay_word", last_ft, 32'h04030201);
      op(0, 3'd0, 32'd0, 0, 3'd0, 0, 1, 0);
      pop(SZ_WORD, 1);
      check_val("replay_tail", last_ft, 32'h08070605);

      // Underflow on empty.
      pop(SZ_BYTE, 0);
      idle();

      // Flush mid-stream drops the concurrent push.
      push(SZ_WORD, 32'h01020304);
      push(SZ_HALF, 32'h0000BEEF);
      op(1, SZ_WORD, 32'hFFFFFFFF, 0, 3'd0, 0, 0, 1);
      push(SZ_WORD, 32'h12345678);
      pop(SZ_WORD, 1);
      check_val("post_flush", last_ft, 32'h12345678);

      // Oversize codes clamp to a full beat; simultaneous push and pop.
      push(3'd7, 32'hCAFEF00D);
      op(1, SZ_DWORD, 32'h55667788, 1, 3'd5, 1, 0, 0);
      check_val("clamp_word", last_ft, 32'hCAFEF00D);
      pop(SZ_WORD, 1);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 99);
         op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), r < 30, r >= 94, r == 50);
      end

      // Asynchronous reset during a push.
      op(0, 3'd0, 32'd0, 0, 3'd0, 0, 0, 1);
      for (int i = 0; i < 3; i++) push(SZ_WORD, 32'hA0B0C0D0 + 32'(i));
      pop(SZ_WORD, 0);
      push(SZ_BYTE, 32'h77);
      bus_ft.wr_en = 1; bus_ft.wr_size = SZ_WORD; bus_ft.wr_data = 32'h13579BDF;
      #2;
      reset = 1'b0;
      #1;
      check_reset_state("async_reset");
      @(posedge clk);
      #1;
      drive_idle();
      sb_q.delete();
      rd_off  = 0;
      exp_reg = '0;
      reset   = 1'b1;
      push(SZ_WORD, 32'h0BADF00D);
      pop(SZ_WORD, 1);
      check_val("after_reset", last_ft, 32'h0BADF00D);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
